// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle control unit of the 16-bit
// register-window CPU: FSM state encoding, opcode constants, RTYPE function
// bit positions, ALU_control encodings, sel_pc encodings and a decode-action
// enum used by the controller's DECODE step.
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Opcodes (IR[15:12]); every other value is illegal.
    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_STORE  = 4'b0001;
    localparam logic [3:0] OP_JUMP   = 4'b0010;
    localparam logic [3:0] OP_SETWIN = 4'b0011;
    localparam logic [3:0] OP_BRZ    = 4'b0100;
    localparam logic [3:0] OP_HALT   = 4'b0111;
    localparam logic [3:0] OP_RTYPE  = 4'b1000;
    localparam logic [3:0] OP_ADDI   = 4'b1100;
    localparam logic [3:0] OP_SUBI   = 4'b1101;
    localparam logic [3:0] OP_ANDI   = 4'b1110;
    localparam logic [3:0] OP_ORI    = 4'b1111;

    // RTYPE one-hot function bit positions (IR[7:0]).
    localparam int FN_MOVE = 0;
    localparam int FN_ADD  = 1;
    localparam int FN_SUB  = 2;
    localparam int FN_AND  = 3;
    localparam int FN_OR   = 4;
    localparam int FN_NOT  = 5;

    // ALU_control encodings.
    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;
    localparam logic [2:0] ALU_NOT    = 3'b100;
    localparam logic [2:0] ALU_PASS_B = 3'b101;

    // sel_pc encodings.
    localparam logic [1:0] SEL_PC_INC    = 2'd0;  // pc + 1
    localparam logic [1:0] SEL_PC_BRANCH = 2'd1;  // {pc[9:8], imm8}
    localparam logic [1:0] SEL_PC_JUMP   = 2'd2;  // IR[9:0]
    localparam logic [1:0] SEL_PC_ZERO   = 2'd3;  // 10'b0

    // What the DECODE step does with the instruction currently in IR.
    typedef enum logic [2:0] {
        ACT_NOP,     // retire in 2 cycles with pc+1
        ACT_JUMP,
        ACT_SETWIN,
        ACT_HALT,
        ACT_TRAP,    // illegal instruction halts (trap build only)
        ACT_MEM,     // LOAD / STORE
        ACT_EXEC     // BRZ, immediates, valid RTYPE
    } action_t;

    // True only for the six defined one-hot RTYPE functions.
    function automatic logic rtype_fn_valid(input logic [7:0] funct);
        return (funct != 8'h00) && ((funct & 8'hC0) == 8'h00) &&
               ((funct & (funct - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// -----------------------------------------------------------------------------
// mc_alu_decode
// Combinational map from (opcode, function) to the ALU operation and the
// immediate-operand select. Shared by S_EXEC and S_WB so the ALU inputs stay
// stable while the register file writes the result.
// Ports:
//   opcode        in  4  IR[15:12]
//   funct         in  8  IR[7:0]
//   alu_control   out 3  ALU operation
//   sel_immediate out 1  ALU B = sign-extended imm8
// -----------------------------------------------------------------------------
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [7:0] funct,
    output logic [2:0] alu_control,
    output logic       sel_immediate
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_control   = ALU_ADD;
        sel_immediate = 1'b0;
        case (opcode)
            OP_ADDI: begin alu_control = ALU_ADD; sel_immediate = 1'b1; end
            OP_SUBI: begin alu_control = ALU_SUB; sel_immediate = 1'b1; end
            OP_ANDI: begin alu_control = ALU_AND; sel_immediate = 1'b1; end
            OP_ORI:  begin alu_control = ALU_OR;  sel_immediate = 1'b1; end
            OP_BRZ:  alu_control = ALU_PASS_B;
            OP_RTYPE: begin
                // Only reached with a valid one-hot function; priority order
                // is irrelevant then.
                if      (funct[FN_MOVE]) alu_control = ALU_PASS_B;
                else if (funct[FN_ADD])  alu_control = ALU_ADD;
                else if (funct[FN_SUB])  alu_control = ALU_SUB;
                else if (funct[FN_AND])  alu_control = ALU_AND;
                else if (funct[FN_OR])   alu_control = ALU_OR;
                else if (funct[FN_NOT])  alu_control = ALU_NOT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multicycle control unit for the 16-bit register-window CPU datapath.
// FSM: S_FETCH -> S_DECODE -> {S_EXEC | S_MEM} -> S_WB -> S_FETCH, plus the
// absorbing S_HALT. Owns the architectural register window and halt state.
// Optional build macro: MC_CTRL_ILLEGAL_TRAP_EN -- illegal opcodes and bad
// RTYPE functions halt the CPU and raise illegal_op; otherwise they retire as
// 2-cycle NOPs and the illegal_op port does not exist.
// Ports:
//   clk                  in  1  system clock, rising edge
//   rst                  in  1  asynchronous, active-low reset
//   instruction_opcode   in  4  IR[15:12]
//   instruction_function in  8  IR[7:0]
//   ALU_zero             in  1  ALU result == 0
//   ir_en                out 1  IR load enable
//   pc_en                out 1  PC load enable (one pulse per retired instr)
//   sel_pc               out 2  PC source select
//   write_signal         out 1  register file write
//   sel_immediate        out 1  ALU B = sign-extended imm8
//   mem_read / mem_write out 1  data memory strobes
//   sel_write_data       out 1  0 = ALU result, 1 = mem_out
//   ALU_control          out 3  ALU operation
//   reg_window           out 2  current register window
//   halted               out 1  FSM in S_HALT
//   illegal_op           out 1  halt caused by trap (trap build only)
// -----------------------------------------------------------------------------
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter logic [1:0] RESET_WINDOW = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] instruction_opcode,
    input  logic [7:0] instruction_function,
    input  logic       ALU_zero,
    output logic       ir_en,
    output logic       pc_en,
    output logic [1:0] sel_pc,
    output logic       write_signal,
    output logic       sel_immediate,
    output logic       mem_read,
    output logic       mem_write,
    output logic       sel_write_data,
    output logic [2:0] ALU_control,
    output logic [1:0] reg_window,
    output logic       halted
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    state_t     state, state_next;
    action_t    action;
    logic [2:0] alu_ctrl_dec;
    logic       sel_imm_dec;

    mc_alu_decode u_alu_decode (
        .opcode        (instruction_opcode),
        .funct         (instruction_function),
        .alu_control   (alu_ctrl_dec),
        .sel_immediate (sel_imm_dec)
    );

    // Classify the instruction held in IR (stable from DECODE to retirement).
    always_comb begin
        action = ACT_NOP;
        case (instruction_opcode)
            OP_JUMP:                           action = ACT_JUMP;
            OP_SETWIN:                         action = ACT_SETWIN;
            OP_HALT:                           action = ACT_HALT;
            OP_LOAD, OP_STORE:                 action = ACT_MEM;
            OP_BRZ, OP_ADDI, OP_SUBI,
            OP_ANDI, OP_ORI:                   action = ACT_EXEC;
            OP_RTYPE: begin
                if (rtype_fn_valid(instruction_function))
                    action = ACT_EXEC;
                else if (instruction_function == 8'h00)
                    action = ACT_NOP;
                else
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    action = ACT_TRAP;
`else
                    action = ACT_NOP;
`endif
            end
            default:
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                action = ACT_TRAP;
`else
                action = ACT_NOP;
`endif
        endcase
    end

    // State register and architectural state. Reset mid-instruction simply
    // returns to S_FETCH; all strobes decode from state, so nothing fires.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FETCH;
            reg_window <= RESET_WINDOW;
        end else begin
            state <= state_next;
            // The new window is visible from the next instruction's FETCH.
            if (state == S_DECODE && action == ACT_SETWIN)
                reg_window <= instruction_function[1:0];
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    // Sticky until reset; set on the same edge that enters S_HALT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            illegal_op <= 1'b0;
        else if (state == S_DECODE && action == ACT_TRAP)
            illegal_op <= 1'b1;
    end
`endif

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (action)
                    ACT_JUMP, ACT_SETWIN, ACT_NOP: state_next = S_FETCH;
                    ACT_HALT, ACT_TRAP:            state_next = S_HALT;
                    ACT_MEM:                       state_next = S_MEM;
                    default:                       state_next = S_EXEC;
                endcase
            end
            S_EXEC:  state_next = (instruction_opcode == OP_BRZ) ? S_FETCH : S_WB;
            S_MEM:   state_next = (instruction_opcode == OP_STORE) ? S_FETCH : S_WB;
            S_WB:    state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // Output decode.
    always_comb begin
        ir_en          = 1'b0;
        pc_en          = 1'b0;
        sel_pc         = SEL_PC_INC;
        write_signal   = 1'b0;
        sel_immediate  = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        sel_write_data = 1'b0;
        ALU_control    = ALU_ADD;
        halted         = 1'b0;
        case (state)
            S_FETCH: ir_en = 1'b1;
            S_DECODE: begin
                case (action)
                    ACT_JUMP: begin
                        pc_en  = 1'b1;
                        sel_pc = SEL_PC_JUMP;
                    end
                    ACT_SETWIN, ACT_NOP: pc_en = 1'b1;
                    default: ;
                endcase
            end
            S_EXEC: begin
                ALU_control   = alu_ctrl_dec;
                sel_immediate = sel_imm_dec;
                if (instruction_opcode == OP_BRZ) begin
                    // ALU_zero reflects PASS_B of this very cycle.
                    pc_en  = 1'b1;
                    sel_pc = ALU_zero ? SEL_PC_BRANCH : SEL_PC_INC;
                end
            end
            S_MEM: begin
                if (instruction_opcode == OP_STORE) begin
                    mem_write = 1'b1;
                    pc_en     = 1'b1;
                end else begin
                    mem_read = 1'b1;
                end
            end
            S_WB: begin
                ALU_control    = alu_ctrl_dec;
                sel_immediate  = sel_imm_dec;
                write_signal   = 1'b1;
                pc_en          = 1'b1;
                sel_write_data = (instruction_opcode == OP_LOAD);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
// Self-checking bench for mc_controller. A per-instruction reference model
// turns (opcode, function, zero) into the expected output vector for every
// cycle of that instruction, derived from the cycle counts and per-cycle
// actions of each instruction class. Directed cases cover reset, each class
// and halting; a randomized stream follows. Define MC_CTRL_ILLEGAL_TRAP_EN to
// check the trap build.
// -----------------------------------------------------------------------------
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] instruction_opcode = 4'h0;
    logic [7:0] instruction_function = 8'h00;
    logic       ALU_zero = 1'b0;
    logic       ir_en, pc_en, write_signal, sel_immediate;
    logic       mem_read, mem_write, sel_write_data, halted;
    logic [1:0] sel_pc, reg_window;
    logic [2:0] ALU_control;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    mc_controller #(.RESET_WINDOW(2'b00)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction_opcode   (instruction_opcode),
        .instruction_function (instruction_function),
        .ALU_zero             (ALU_zero),
        .ir_en                (ir_en),
        .pc_en                (pc_en),
        .sel_pc               (sel_pc),
        .write_signal         (write_signal),
        .sel_immediate        (sel_immediate),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .sel_write_data       (sel_write_data),
        .ALU_control          (ALU_control),
        .reg_window           (reg_window),
        .halted               (halted)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op           (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic [1:0] sel_pc;
        logic       write_signal;
        logic       sel_immediate;
        logic       mem_read;
        logic       mem_write;
        logic       sel_write_data;
        logic [2:0] alu;
        logic [1:0] win;
        logic       halted;
    } outs_t;

    outs_t obs;
    assign obs = {ir_en, pc_en, sel_pc, write_signal, sel_immediate, mem_read,
                  mem_write, sel_write_data, ALU_control, reg_window, halted};

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_instr  = 0;
    logic [1:0] m_window = 2'b00;
    outs_t      exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Called #1 after a rising edge; leaves the DUT in FETCH with rst high.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        // Everything except ir_en (FETCH decode) must be quiet, window at 0.
        check("reset_outs", 32'(obs[13:0]), 32'h0);
        #1;
        rst = 1'b1;
        m_window = 2'b00;
    endtask

    // Model one instruction and step the DUT through it, checking each cycle.
    // Precondition: #1 after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [3:0] op, input logic [7:0] fn, input logic z);
        outs_t      base, e;
        int         n;
        bit         halts, trap, is_alu;
        logic [2:0] alu;
        logic       imm;
        base = '0;
        base.win = m_window;
        halts = 0; trap = 0; is_alu = 0; alu = 3'd0; imm = 1'b0; n = 2;
        case (op)
            4'h0: n = 4;                         // LOAD
            4'h1: n = 3;                         // STORE
            4'h2, 4'h3: n = 2;                   // JUMP, SETWIN
            4'h4: begin n = 3; alu = 3'd5; end   // BRZ, PASS_B
            4'h7: halts = 1;                     // HALT
            4'h8: begin
                case (fn)
                    8'h01: begin is_alu = 1; alu = 3'd5; end
                    8'h02: begin is_alu = 1; alu = 3'd0; end
                    8'h04: begin is_alu = 1; alu = 3'd1; end
                    8'h08: begin is_alu = 1; alu = 3'd2; end
                    8'h10: begin is_alu = 1; alu = 3'd3; end
                    8'h20: begin is_alu = 1; alu = 3'd4; end
                    8'h00: n = 2;
                    default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        halts = 1; trap = 1;
`else
                        n = 2;
`endif
                    end
                endcase
                if (is_alu) n = 4;
            end
            4'hC, 4'hD, 4'hE, 4'hF: begin
                is_alu = 1; imm = 1'b1; alu = 3'(op - 4'hC); n = 4;
            end
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                halts = 1; trap = 1;
`else
                n = 2;
`endif
            end
        endcase

        exp_q.delete();
        e = base; e.ir_en = 1'b1;
        exp_q.push_back(e);
        if (halts) begin
            e = base;
            exp_q.push_back(e);
            repeat (20) begin
                e = base; e.halted = 1'b1;
                exp_q.push_back(e);
            end
        end else begin
            for (int c = 2; c <= n; c++) begin
                e = base;
                if (c >= 3 && (is_alu || op == 4'h4)) begin
                    e.alu = alu;
                    e.sel_immediate = imm;
                end
                if (op == 4'h0 && c == 3) e.mem_read = 1'b1;
                if (op == 4'h0 && c == 4) begin e.write_signal = 1'b1; e.sel_write_data = 1'b1; end
                if (op == 4'h1 && c == 3) e.mem_write = 1'b1;
                if (is_alu && c == 4) e.write_signal = 1'b1;
                if (c == n) begin
                    e.pc_en = 1'b1;
                    if (op == 4'h2)           e.sel_pc = 2'd2;
                    else if (op == 4'h4 && z) e.sel_pc = 2'd1;
                    else                      e.sel_pc = 2'd0;
                end
                exp_q.push_back(e);
            end
        end

        instruction_opcode   = op;
        instruction_function = fn;
        ALU_zero             = z;
        foreach (exp_q[k]) begin
            @(negedge clk);
            check($sformatf("i%0d_op%h_fn%h_c%0d", n_instr, op, fn, k + 1), 32'(obs), 32'(exp_q[k]));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            check($sformatf("i%0d_illegal_op_c%0d", n_instr, k + 1), 32'(illegal_op),
                  32'(trap && exp_q[k].halted));
`endif
            @(posedge clk);
            #1;
        end
        n_instr++;
        if (halts) do_reset();
        else if (op == 4'h3) m_window = fn[1:0];
    endtask

    initial begin
        logic [3:0] op;
        logic [7:0] fn;
        int         r;

        // Power-on reset.
        #3;
        check("por_outs", 32'(obs[13:0]), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset aborting ADDI in S_EXEC, from a non-default window.
        run_instr(4'h3, 8'h03, 1'b0);
        instruction_opcode   = 4'hC;
        instruction_function = 8'h5A;
        @(negedge clk);
        check("addi_abort_fetch_ir_en", 32'(ir_en), 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("addi_abort_exec_alu", 32'({ALU_control, sel_immediate, reg_window}), 32'({3'b000, 1'b1, 2'b11}));
        #1;
        rst = 1'b0;
        #1;
        check("abort_reset_outs", 32'(obs[13:0]), 32'h0);
        @(posedge clk); #1;
        check("abort_reset_hold", 32'(obs[13:0]), 32'h0);
        rst = 1'b1;
        m_window = 2'b00;

        // Directed classes.
        run_instr(4'hC, 8'h11, 1'b0);   // ADDI
        run_instr(4'h0, 8'h20, 1'b0);   // LOAD
        run_instr(4'h1, 8'h20, 1'b0);   // STORE
        run_instr(4'h4, 8'h07, 1'b1);   // BRZ taken
        run_instr(4'h4, 8'h07, 1'b0);   // BRZ not taken
        run_instr(4'h2, 8'h33, 1'b0);   // JUMP
        run_instr(4'h3, 8'h02, 1'b0);   // SETWIN -> window 2
        run_instr(4'h8, 8'h02, 1'b0);   // RTYPE ADD in window 2
        run_instr(4'h8, 8'h00, 1'b0);   // RTYPE NOP
        run_instr(4'h8, 8'h06, 1'b0);   // non-one-hot function
        run_instr(4'h5, 8'h00, 1'b0);   // illegal opcode
        run_instr(4'h7, 8'h00, 1'b0);   // HALT, then reset

        // Randomized stream.
        repeat (300) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h8) begin
                r = int'($urandom_range(0, 9));
                if (r < 6)       fn = 8'(1 << r);
                else if (r == 6) fn = 8'h00;
                else             fn = 8'($urandom);
            end else begin
                fn = 8'($urandom);
            end
            run_instr(op, fn, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit for the 16-bit register-window CPU datapath; the controlling end of the datapath's control interface.
- Consumes opcode, function field and ALU zero flag from the datapath.
- Drives every datapath select/enable, plus a PC load enable and an instruction-register enable.
- Owns the architectural register-window state and the halt state.

Parameters:
- RESET_WINDOW, 2'b00, reg_window value after reset.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- instruction_opcode  input  4  IR[15:12]
- instruction_function  input  8  IR[7:0]
- ALU_zero  input  1  ALU result == 0
- ir_en  output  1  IR captures instruction_mem output at this edge
- pc_en  output  1  PC loads pc_load at this edge
- sel_pc  output  2  0 = pc+1, 1 = {pc[9:8],imm8}, 2 = IR[9:0], 3 = 10'b0
- write_signal  output  1  register file write
- sel_immediate  output  1  ALU B = sign-extended imm8
- mem_read  output  1  data memory read
- mem_write  output  1  data memory write
- sel_write_data  output  1  0 = ALU result, 1 = mem_out
- ALU_control  output  3  ALU operation
- reg_window  output  2  current register window
- halted  output  1  FSM in S_HALT

Behaviour:
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT.
- Reset (rst low, async): state=S_FETCH, reg_window=RESET_WINDOW, halted=0.
  - All other outputs decode combinationally from state and default to 0.
  - Reset mid-instruction aborts it; no write or PC update is issued.
- Opcodes: 0000 LOAD, 0001 STORE, 0010 JUMP, 0011 SETWIN, 0100 BRZ, 0111 HALT, 1000 RTYPE, 1100 ADDI, 1101 SUBI, 1110 ANDI, 1111 ORI. All others are illegal.
- RTYPE function is one-hot:
  - bit0 MOVE, bit1 ADD, bit2 SUB, bit3 AND, bit4 OR, bit5 NOT.
  - 8'h00 is NOP. Any other value is treated as NOP.
- ALU_control: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 PASS_B.
- S_FETCH: ir_en=1 -> S_DECODE.
- S_DECODE (register file read):
  - JUMP: sel_pc=2, pc_en=1 -> S_FETCH.
  - SETWIN: reg_window<=function[1:0], sel_pc=0, pc_en=1 -> S_FETCH. The new window takes effect on the next instruction.
  - NOP/illegal: pc_en=1, sel_pc=0 -> S_FETCH.
  - HALT -> S_HALT, no pc_en.
  - LOAD/STORE -> S_MEM.
  - All others -> S_EXEC.
- S_EXEC:
  - ALU_control per op; sel_immediate=1 for ADDI/SUBI/ANDI/ORI.
  - BRZ: ALU_control=PASS_B. If ALU_zero=1, sel_pc=1, else sel_pc=0; pc_en=1 -> S_FETCH. ALU_zero is sampled in this same cycle.
  - Otherwise -> S_WB; the ALU control and sel_immediate values are held into S_WB.
- S_MEM:
  - STORE: mem_write=1, pc_en=1, sel_pc=0 -> S_FETCH.
  - LOAD: mem_read=1 -> S_WB.
- S_WB:
  - write_signal=1, pc_en=1, sel_pc=0.
  - sel_write_data=1 for LOAD, else 0.
  - -> S_FETCH.
- Cycles per instruction: JUMP/SETWIN/NOP 2; BRZ/STORE 3; LOAD/ALU 4.
- S_HALT: absorbing. halted=1, all enables 0; only reset exits.
- Exactly one pc_en pulse per retired instruction. write_signal and mem_write are never high in the same cycle.
- pc+1 wraps 10'h3FF -> 10'h000 (datapath adder; the controller does no special handling).

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal opcode in S_DECODE -> S_HALT.
  - Adds output port illegal_op (1 bit), asserted from entry to S_HALT while the halt was caused by the trap; cleared only by reset.
  - Non-one-hot RTYPE function also traps.
- Undefined: illegal opcodes and bad functions execute as 2-cycle NOPs; no illegal_op port.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - RTYPE function bit positions;
  - ALU_control encodings;
  - sel_pc encodings.
- One sub-module is natural: mc_alu_decode, a combinational map from (opcode, function) to ALU_control and sel_immediate, shared by S_EXEC and S_WB.

Test Plan:
- Reset: rst low mid-S_EXEC of ADDI -> state S_FETCH, all enables 0, reg_window=00. After release: ir_en=1 on the first cycle.
- ADDI (opcode 1100): cycles FETCH/DECODE/EXEC/WB. EXEC: ALU_control=000, sel_immediate=1. WB: write_signal=1, sel_write_data=0, pc_en=1, sel_pc=0.
- LOAD then STORE:
  - LOAD: mem_read=1 in cycle 3; write_signal=1 and sel_write_data=1 in cycle 4.
  - STORE: mem_write=1 and pc_en=1 in cycle 3; write_signal stays 0.
- BRZ (0100) twice: ALU_zero=1 -> sel_pc=1 with pc_en in cycle 3; ALU_zero=0 -> sel_pc=0 with pc_en in cycle 3.
- SETWIN function=8'h02 then RTYPE ADD (function 8'h02): reg_window=10 from the cycle after the SETWIN pc_en; ADD EXEC has ALU_control=000.
- HALT (0111): halted=1 from cycle 3 and stays; no further ir_en/pc_en over 20 cycles. Opcode 0101: NOP in 2 cycles, or with MC_CTRL_ILLEGAL_TRAP_EN -> halted=1, illegal_op=1.
